// File: rtl/ap_ctrl_sequencer.sv
// ap_ctrl_chain sequencer: issues N kernel invocations with bounded overlap.
// Define AP_CTRL_SEQ_LATENCY_STATS_EN to build per-invocation latency stats.
module ap_ctrl_sequencer #(
    parameter int CNT_W           = 16,
    parameter int MAX_OUTSTANDING = 2,
    parameter int LAT_W           = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [CNT_W-1:0] cfg_count,
    input  logic             cmd_start,
    input  logic             cmd_abort,
    input  logic             sink_ready,
    output logic             k_ap_start,
    input  logic             k_ap_ready,
    input  logic             k_ap_done,
    output logic             k_ap_continue,
    output logic             busy,
    output logic             done,
    output logic             aborted,
    output logic             err,
    output logic [CNT_W-1:0] issued_cnt,
    output logic [CNT_W-1:0] completed_cnt,
    output logic [LAT_W-1:0] total_cycles,
    output logic [LAT_W-1:0] last_latency,
    output logic [LAT_W-1:0] max_latency
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_e;

    localparam logic [CNT_W-1:0] MAX_OUT = CNT_W'(MAX_OUTSTANDING);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] target_q, target_d;
    logic [CNT_W-1:0] issued_q, issued_d;
    logic [CNT_W-1:0] completed_q, completed_d;
    logic [LAT_W-1:0] cycles_q, cycles_d;
    logic             aborted_q, aborted_d;
    logic             err_q, err_d;

    logic [CNT_W-1:0] outstanding;
    logic             active;
    logic             launch;
    logic             issue_ev;
    logic             cmpl_ev;
    logic             cmpl_ok;

    assign outstanding = issued_q - completed_q;
    assign active      = (state_q == S_RUN) || (state_q == S_DRAIN);
    assign launch      = cmd_start && ((state_q == S_IDLE) || (state_q == S_DONE));
    assign issue_ev    = k_ap_start && k_ap_ready;
    assign cmpl_ev     = k_ap_done && k_ap_continue;
    assign cmpl_ok     = cmpl_ev && (outstanding != '0);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            target_q    <= '0;
            issued_q    <= '0;
            completed_q <= '0;
            cycles_q    <= '0;
            aborted_q   <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            target_q    <= target_d;
            issued_q    <= issued_d;
            completed_q <= completed_d;
            cycles_q    <= cycles_d;
            aborted_q   <= aborted_d;
            err_q       <= err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        target_d    = target_q;
        issued_d    = issued_q;
        completed_d = completed_q;
        cycles_d    = cycles_q;
        aborted_d   = aborted_q;
        err_d       = err_q;
        if (launch) begin
            target_d    = cfg_count;
            issued_d    = '0;
            completed_d = '0;
            cycles_d    = '0;
            aborted_d   = 1'b0;
            err_d       = 1'b0;
            state_d     = S_RUN;
        end else if (active) begin
            if (cycles_q != '1) cycles_d = cycles_q + LAT_W'(1);
            if (issue_ev) issued_d = issued_q + CNT_W'(1);
            if (cmpl_ok) completed_d = completed_q + CNT_W'(1);
            if (cmpl_ev && !cmpl_ok) err_d = 1'b1;
            case (state_q)
                S_RUN: begin
                    if (cmd_abort) begin
                        target_d  = issued_d;
                        aborted_d = 1'b1;
                    end
                    // nothing left in flight (empty or early-aborted run): skip DRAIN
                    if (issued_d == target_d)
                        state_d = (completed_d == issued_d) ? S_DONE : S_DRAIN;
                end
                S_DRAIN: begin
                    if (completed_d == issued_d) state_d = S_DONE;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        k_ap_start    = (state_q == S_RUN) && (issued_q < target_q)
                        && (outstanding < MAX_OUT);
        k_ap_continue = sink_ready && active;
        busy          = active;
        done          = (state_q == S_DONE);
        aborted       = aborted_q;
        err           = err_q;
        issued_cnt    = issued_q;
        completed_cnt = completed_q;
        total_cycles  = cycles_q;
    end

`ifdef AP_CTRL_SEQ_LATENCY_STATS_EN
    localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam logic [PW-1:0] PTR_LAST = PW'(MAX_OUTSTANDING - 1);

    logic [LAT_W-1:0] ts_q [MAX_OUTSTANDING];
    logic [PW-1:0]    wr_q, rd_q;
    logic [LAT_W-1:0] last_q, max_q;
    logic [LAT_W-1:0] lat;

    // the outstanding limit bounds occupancy, so no full/empty flags are needed
    assign lat = cycles_q - ts_q[rd_q];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < MAX_OUTSTANDING; i++) ts_q[i] <= '0;
            wr_q   <= '0;
            rd_q   <= '0;
            last_q <= '0;
            max_q  <= '0;
        end else if (launch) begin
            wr_q   <= '0;
            rd_q   <= '0;
            last_q <= '0;
            max_q  <= '0;
        end else begin
            if (issue_ev) begin
                ts_q[wr_q] <= cycles_q;
                wr_q       <= (wr_q == PTR_LAST) ? '0 : wr_q + PW'(1);
            end
            if (cmpl_ok) begin
                rd_q   <= (rd_q == PTR_LAST) ? '0 : rd_q + PW'(1);
                last_q <= lat;
                if (lat > max_q) max_q <= lat;
            end
        end
    end

    assign last_latency = last_q;
    assign max_latency  = max_q;
`else
    assign last_latency = '0;
    assign max_latency  = '0;
`endif

endmodule

// File: tb/tb_ap_ctrl_sequencer.sv
// Randomized bench for ap_ctrl_sequencer against a queue-based reference
// model plus a behavioural kernel with configurable ready/done timing.
module tb_ap_ctrl_sequencer;

    localparam int CW = 16;
    localparam int MO = 2;
    localparam int LW = 10;
    localparam longint CYC_MAX = (64'd1 << LW) - 1;

    logic          clock;
    logic          reset;
    logic [CW-1:0] cfg_count;
    logic          cmd_start;
    logic          cmd_abort;
    logic          sink_ready;
    logic          k_ap_start;
    logic          k_ap_ready;
    logic          k_ap_done;
    logic          k_ap_continue;
    logic          busy;
    logic          done;
    logic          aborted;
    logic          err;
    logic [CW-1:0] issued_cnt;
    logic [CW-1:0] completed_cnt;
    logic [LW-1:0] total_cycles;
    logic [LW-1:0] last_latency;
    logic [LW-1:0] max_latency;

    ap_ctrl_sequencer #(
        .CNT_W(CW),
        .MAX_OUTSTANDING(MO),
        .LAT_W(LW)
    ) dut (
        .clock(clock),
        .reset(reset),
        .cfg_count(cfg_count),
        .cmd_start(cmd_start),
        .cmd_abort(cmd_abort),
        .sink_ready(sink_ready),
        .k_ap_start(k_ap_start),
        .k_ap_ready(k_ap_ready),
        .k_ap_done(k_ap_done),
        .k_ap_continue(k_ap_continue),
        .busy(busy),
        .done(done),
        .aborted(aborted),
        .err(err),
        .issued_cnt(issued_cnt),
        .completed_cnt(completed_cnt),
        .total_cycles(total_cycles),
        .last_latency(last_latency),
        .max_latency(max_latency)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    typedef enum int {M_IDLE, M_RUN, M_DRAIN, M_DONE} mph_e;
    mph_e   ph;
    longint m_tgt, m_iss, m_cmp, m_cyc, m_last, m_max;
    bit     m_ab, m_err;
    longint m_ts[$];

    longint kdue[$];
    longint gcyc;
    int     klat;
    int     p_sink, p_ready;
    bit     f_start, f_abort, f_spur;
    int     f_cfg;
    longint mo_seen;

    function automatic void model_clear();
        ph = M_IDLE;
        m_tgt = 0; m_iss = 0; m_cmp = 0; m_cyc = 0;
        m_last = 0; m_max = 0; m_ab = 0; m_err = 0;
        m_ts.delete();
    endfunction

    task automatic step();
        bit sink, rdy, kd, e_start, e_cont, iss, cev;
        longint ts;
        sink = ($urandom_range(99) < p_sink);
        rdy  = ($urandom_range(99) < p_ready);
        kd   = (kdue.size() > 0 && kdue[0] <= gcyc) || f_spur;
        sink_ready = sink;
        k_ap_ready = rdy;
        k_ap_done  = kd;
        cmd_start  = f_start;
        cmd_abort  = f_abort;
        cfg_count  = CW'(f_cfg);
        #1;
        e_start = (ph == M_RUN) && (m_iss < m_tgt) && (m_iss - m_cmp < MO);
        e_cont  = sink && (ph == M_RUN || ph == M_DRAIN);
        chk("k_ap_start", k_ap_start, e_start);
        chk("k_ap_continue", k_ap_continue, e_cont);
        chk("busy", busy, ph == M_RUN || ph == M_DRAIN);
        chk("done", done, ph == M_DONE);
        chk("aborted", aborted, m_ab);
        chk("err", err, m_err);
        chk("issued_cnt", issued_cnt, m_iss);
        chk("completed_cnt", completed_cnt, m_cmp);
        chk("total_cycles", total_cycles, m_cyc);
`ifdef AP_CTRL_SEQ_LATENCY_STATS_EN
        chk("last_latency", last_latency, m_last);
        chk("max_latency", max_latency, m_max);
`else
        chk("last_latency", last_latency, 0);
        chk("max_latency", max_latency, 0);
`endif
        if (longint'(issued_cnt - completed_cnt) > mo_seen)
            mo_seen = longint'(issued_cnt - completed_cnt);
        iss = e_start && rdy;
        cev = kd && e_cont;
        if ((ph == M_IDLE || ph == M_DONE) && f_start) begin
            model_clear();
            m_tgt = f_cfg;
            ph = M_RUN;
        end else if (ph == M_RUN || ph == M_DRAIN) begin
            if (cev && m_iss == m_cmp) m_err = 1;
            if (cev && m_iss > m_cmp) begin
                ts = m_ts.pop_front();
                m_last = m_cyc - ts;
                if (m_last > m_max) m_max = m_last;
                m_cmp++;
            end
            if (iss) begin
                m_ts.push_back(m_cyc);
                m_iss++;
            end
            if (m_cyc < CYC_MAX) m_cyc++;
            if (ph == M_RUN) begin
                if (f_abort) begin
                    m_tgt = m_iss;
                    m_ab = 1;
                end
                if (m_iss == m_tgt) ph = (m_iss == m_cmp) ? M_DONE : M_DRAIN;
            end else if (m_iss == m_cmp) begin
                ph = M_DONE;
            end
        end
        if (kdue.size() > 0 && kdue[0] <= gcyc && e_cont) void'(kdue.pop_front());
        if (iss) kdue.push_back(gcyc + klat);
        f_start = 0;
        f_abort = 0;
        f_spur  = 0;
        @(posedge clock);
        #1;
        gcyc++;
    endtask

    task automatic launch(input int cfg);
        f_cfg   = cfg;
        f_start = 1;
        step();
    endtask

    task automatic run_to_done(input int budget);
        int n = 0;
        while (ph != M_DONE && n < budget) begin
            step();
            n++;
        end
        chk("run_timeout", ph != M_DONE, 0);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        #1;
        model_clear();
        kdue.delete();
        @(posedge clock);
        #1;
        reset = 1'b1;
        gcyc++;
    endtask

    bit start_seen;

    initial begin
        reset = 1'b1;
        cfg_count = '0; cmd_start = 0; cmd_abort = 0;
        sink_ready = 0; k_ap_ready = 0; k_ap_done = 0;
        f_start = 0; f_abort = 0; f_spur = 0; f_cfg = 0;
        gcyc = 0; klat = 5; p_sink = 100; p_ready = 100; mo_seen = 0;
        model_clear();
        #2;
        do_reset();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_start", k_ap_start, 0);
        chk("rst_issued", issued_cnt, 0);

        f_spur = 1;
        step();
        chk("idle_spur_err", err, 0);

        launch(4);
        run_to_done(200);
        chk("t1_issued", issued_cnt, 4);
        chk("t1_completed", completed_cnt, 4);
        chk("t1_done", done, 1);
        chk("t1_err", err, 0);
        chk("t1_aborted", aborted, 0);
        chk("t1_max_out", mo_seen > MO, 0);

        launch(0);
        start_seen = 0;
        step();
        start_seen = k_ap_start;
        chk("t2_done", done, 1);
        chk("t2_start", start_seen, 0);
        chk("t2_issued", issued_cnt, 0);

        p_sink = 0;
        launch(6);
        repeat (12) step();
        chk("t3_issued", issued_cnt, 2);
        chk("t3_completed", completed_cnt, 0);
        chk("t3_cont", k_ap_continue, 0);
        p_sink = 100;
        run_to_done(300);
        chk("t3_final", completed_cnt, 6);

        launch(10);
        for (int i = 0; i < 50 && m_iss < 2; i++) step();
        f_abort = 1;
        step();
        chk("t4_start", k_ap_start, 0);
        run_to_done(200);
        chk("t4_issued", issued_cnt, 2);
        chk("t4_completed", completed_cnt, 2);
        chk("t4_aborted", aborted, 1);

        p_ready = 0;
        launch(3);
        step();
        f_spur = 1;
        step();
        chk("t5_err", err, 1);
        chk("t5_completed", completed_cnt, 0);
        p_ready = 100;
        run_to_done(200);

        launch(5);
        repeat (3) step();
        reset = 1'b0;
        #1;
        chk("t6_start_async", k_ap_start, 0);
        chk("t6_issued", issued_cnt, 0);
        chk("t6_busy", busy, 0);
        @(posedge clock);
        #1;
        reset = 1'b1;
        gcyc++;
        model_clear();
        kdue.delete();
        klat = 7;
        launch(3);
        run_to_done(200);
`ifdef AP_CTRL_SEQ_LATENCY_STATS_EN
        chk("t6_last_lat", last_latency, 7);
        chk("t6_max_lat", max_latency, 7);
`else
        chk("t6_last_lat", last_latency, 0);
`endif

        p_ready = 0;
        launch(20);
        repeat (1030) step();
        chk("t7_sat", total_cycles, CYC_MAX);
        f_abort = 1;
        step();
        chk("t7_done", done, 1);

        for (int r = 0; r < 40; r++) begin
            int n;
            klat    = $urandom_range(9, 1);
            p_sink  = $urandom_range(100, 30);
            p_ready = $urandom_range(100, 20);
            launch($urandom_range(12));
            n = 0;
            while (ph != M_DONE && n < 3000) begin
                f_abort = ($urandom_range(99) < 1);
                f_start = ($urandom_range(99) < 2);
                f_cfg   = $urandom_range(12);
                f_spur  = (kdue.size() == 0) && ($urandom_range(99) < 2);
                step();
                n++;
            end
            chk("rand_timeout", ph != M_DONE, 0);
            repeat ($urandom_range(3)) step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
